// File: rtl/i2c_target_regfile_if.sv
// Pin-level I2C signals and host register port of the I2C target register file.
// The slave modport is the target's view; the master modport is the bus/host side.
interface i2c_target_regfile_if #(
    parameter int PTR_W = 4
);
    logic             scl_i;
    logic             sda_i;
    logic             sda_oe;
    logic             busy;
    logic             host_we;
    logic [PTR_W-1:0] host_addr;
    logic [7:0]       host_wdata;
    logic [7:0]       host_rdata;
    logic             wr_valid;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic [2:0]       dbg_state;

    // Host side is a plain strobe: a write lands on the clk edge where host_we is high;
    // host_rdata shows regs[host_addr] one clk later; wr_valid is a single-clk pulse.
    modport slave (
        input  scl_i, sda_i, host_we, host_addr, host_wdata,
        output sda_oe, busy, host_rdata, wr_valid, wr_addr, wr_data, dbg_state
    );

    modport master (
        output scl_i, sda_i, host_we, host_addr, host_wdata,
        input  sda_oe, busy, host_rdata, wr_valid, wr_addr, wr_data, dbg_state
    );
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with an internal register file: oversampled SCL/SDA, pointer-addressed
// multi-byte writes, auto-incrementing reads, and a host port for preload/readback.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         REG_DEPTH   = 16,
    parameter int         PTR_W       = $clog2(REG_DEPTH),
    parameter int         FILTER_LEN  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_target_regfile_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]       w_pin;
    logic [1:0]       r_sync1, r_sync2, r_filt, r_filt_d;
    logic [2:0]       r_cnt [2];

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_first, w_first_nxt;
    logic             r_rw, w_rw_nxt;
    logic             r_sda_oe, w_sda_oe_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_wr_en;
    logic             r_wr_valid;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_regs [REG_DEPTH];
    logic [7:0]       r_host_rdata;

    logic             w_scl_f, w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]       w_rx_byte, w_rd_byte;

    assign w_pin = {bus.sda_i, bus.scl_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_filt   <= '1;
            r_filt_d <= '1;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_sync1  <= w_pin;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 3'd1;
                end
            end
        end
    end

    assign w_scl_f    = r_filt[0];
    assign w_sda_f    = r_filt[1];
    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    // Qualified only by the current SCL level so a coincident SCL edge cannot mask START/STOP.
    assign w_start    = w_scl_f & r_filt_d[1] & ~w_sda_f;
    assign w_stop     = w_scl_f & ~r_filt_d[1] & w_sda_f;
    assign w_rx_byte  = {r_shift[6:0], w_sda_f};
    assign w_rd_byte  = r_regs[r_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_first_nxt   = r_first;
        w_rw_nxt      = r_rw;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_wr_en       = 1'b0;
        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 3'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rw_nxt = w_sda_f;
                            if (r_shift[6:0] == TARGET_ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                // In the ACK states r_sda_oe doubles as the phase flag: the first SCL
                // fall starts the ACK, the second one ends it.
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else if (r_rw) begin
                            w_state_nxt   = S_RD_BYTE;
                            w_shift_nxt   = w_rd_byte;
                            w_ptr_nxt     = r_ptr + PTR_W'(1);
                            w_sda_oe_nxt  = ~w_rd_byte[7];
                            w_bit_cnt_nxt = 3'd0;
                        end else begin
                            w_state_nxt   = S_WR_BYTE;
                            w_sda_oe_nxt  = 1'b0;
                            w_first_nxt   = 1'b1;
                            w_bit_cnt_nxt = 3'd0;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_WR_ACK;
                            if (r_first) begin
                                w_ptr_nxt   = w_rx_byte[PTR_W-1:0];
                                w_first_nxt = 1'b0;
                            end else begin
                                w_wr_en   = 1'b1;
                                w_ptr_nxt = r_ptr + PTR_W'(1);
                            end
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = S_WR_BYTE;
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 3'd0;
                        end
                    end
                end
                S_RD_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_state_nxt = S_RD_ACK;
                    end else if (w_scl_fall) begin
                        w_sda_oe_nxt = ~r_shift[7];
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        if (!w_sda_f) begin
                            w_state_nxt   = S_RD_BYTE;
                            w_shift_nxt   = w_rd_byte;
                            w_ptr_nxt     = r_ptr + PTR_W'(1);
                            w_bit_cnt_nxt = 3'd0;
                        end else begin
                            w_state_nxt = S_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
                S_IGNORE: w_sda_oe_nxt = 1'b0;
                default:  w_state_nxt  = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_first    <= 1'b0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_first    <= w_first_nxt;
            r_rw       <= w_rw_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_valid <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_rx_byte;
            end
        end
    end

    // I2C write takes precedence over a host write to the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
            r_host_rdata <= '0;
        end else begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                if (w_wr_en && r_ptr == PTR_W'(i))
                    r_regs[i] <= w_rx_byte;
                else if (bus.host_we && bus.host_addr == PTR_W'(i))
                    r_regs[i] <= bus.host_wdata;
            end
            r_host_rdata <= r_regs[bus.host_addr];
        end
    end

    assign bus.sda_oe     = r_sda_oe;
    assign bus.busy       = r_busy;
    assign bus.host_rdata = r_host_rdata;
    assign bus.wr_valid   = r_wr_valid;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C master, host port driver,
// wr_valid scoreboard and immediate-assertion checks with a pass/total summary.
module tb_i2c_target_regfile;
    localparam int PTR_W = 4;
    localparam int W     = PTR_W + 8;

    logic clk = 1'b0;
    logic rst_n;
    logic scl_m, sda_m;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_mem [64];
    int obs_cnt  = 0;
    int obs_rd   = 0;
    int oe_cnt   = 0;
    int busy_cnt = 0;

    logic       ack;
    logic [7:0] rb;
    int         oe0, busy0;

    i2c_target_regfile_if #(.PTR_W(PTR_W)) bus ();

    i2c_target_regfile #(
        .TARGET_ADDR(7'h22),
        .REG_DEPTH  (16),
        .FILTER_LEN (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Open-drain bus: the line is low if either side pulls it low.
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    always @(negedge clk) begin
        if (bus.wr_valid) begin
            obs_mem[obs_cnt % 64] <= {bus.wr_addr, bus.wr_data};
            obs_cnt <= obs_cnt + 1;
        end
        if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
        if (bus.busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(10);
        scl_m = 1'b1; wait_clks(20);
        sda_m = 1'b0; wait_clks(20);
        scl_m = 1'b0; wait_clks(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(10);
        scl_m = 1'b1; wait_clks(20);
        sda_m = 1'b1; wait_clks(20);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clks(10);
        scl_m = 1'b1; wait_clks(20);
        scl_m = 1'b0; wait_clks(10);
    endtask

    task automatic get_ack(output logic a);
        sda_m = 1'b1; wait_clks(10);
        scl_m = 1'b1; wait_clks(10);
        a = bus.sda_i; wait_clks(10);
        scl_m = 1'b0; wait_clks(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_ack(a);
    endtask

    // 1-clk SCL pulses in both the low and high phase of every bit.
    task automatic write_byte_glitch(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_clks(4);
            scl_m = 1'b1; wait_clks(1);
            scl_m = 1'b0; wait_clks(5);
            scl_m = 1'b1; wait_clks(8);
            scl_m = 1'b0; wait_clks(1);
            scl_m = 1'b1; wait_clks(11);
            scl_m = 1'b0; wait_clks(10);
        end
        get_ack(a);
    endtask

    // Host write strobe lands on the clk edge where the target samples data bit 0:
    // pin rise + 2 sync + FILTER_LEN filter + 1 detect = 6th edge after the rise.
    task automatic write_byte_col(input logic [7:0] b, input logic [PTR_W-1:0] ca,
                                  input logic [7:0] cd, output logic a, output logic [7:0] rd);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        sda_m = b[0];
        bus.host_addr  = ca;
        bus.host_wdata = cd;
        wait_clks(10);
        scl_m = 1'b1; wait_clks(5);
        bus.host_we = 1'b1; wait_clks(1);
        bus.host_we = 1'b0; wait_clks(1);
        rd = bus.host_rdata; wait_clks(13);
        scl_m = 1'b0; wait_clks(10);
        get_ack(a);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_clks(10);
            scl_m = 1'b1; wait_clks(10);
            b[i] = bus.sda_i; wait_clks(10);
            scl_m = 1'b0; wait_clks(10);
        end
        sda_m = nack; wait_clks(10);
        scl_m = 1'b1; wait_clks(20);
        scl_m = 1'b0; wait_clks(10);
    endtask

    task automatic host_write(input logic [PTR_W-1:0] a, input logic [7:0] d);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        wait_clks(1);
        bus.host_we    = 1'b0;
    endtask

    task automatic host_check(input string tag, input logic [PTR_W-1:0] a, input logic [7:0] d);
        bus.host_addr = a;
        wait_clks(2);
        check(tag, bus.host_rdata, d);
    endtask

    task automatic check_wr(input string tag);
        check({tag, "_cnt"}, obs_cnt - obs_rd, exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_cnt) begin
            check(tag, obs_mem[obs_rd % 64], exp_q.pop_front());
            obs_rd++;
        end
        obs_rd = obs_cnt;
        exp_q.delete();
    endtask

    initial begin
        // Clock/reset
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        wait_clks(5);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_host_rdata", bus.host_rdata, 0);
        check("rst_state", bus.dbg_state, 0);
        rst_n = 1'b1;
        wait_clks(10);

        // Pointer-addressed multi-byte write
        i2c_start();
        write_byte(8'h44, ack); check("wr_addr_ack", ack, 0);
        check("wr_busy", bus.busy, 1);
        exp_q.push_back({4'd3, 8'hA5});
        exp_q.push_back({4'd4, 8'h5A});
        write_byte(8'h03, ack); check("wr_ptr_ack", ack, 0);
        write_byte(8'hA5, ack); check("wr_d0_ack", ack, 0);
        write_byte(8'h5A, ack); check("wr_d1_ack", ack, 0);
        i2c_stop();
        check("wr_busy_end", bus.busy, 0);
        check("wr_state_idle", bus.dbg_state, 0);
        check_wr("wr_pulse");
        host_check("wr_reg3", 4'd3, 8'hA5);
        host_check("wr_reg4", 4'd4, 8'h5A);
        host_check("wr_reg5", 4'd5, 8'h00);

        // Read with repeated START and pointer wrap
        host_write(4'd14, 8'h11);
        host_write(4'd15, 8'h22);
        host_write(4'd0,  8'h33);
        host_write(4'd1,  8'hC3);
        i2c_start();
        write_byte(8'h44, ack); check("rd_addrw_ack", ack, 0);
        write_byte(8'h0E, ack); check("rd_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h45, ack); check("rd_addrr_ack", ack, 0);
        read_byte(1'b0, rb); check("rd_byte0", rb, 8'h11);
        read_byte(1'b0, rb); check("rd_byte1", rb, 8'h22);
        read_byte(1'b1, rb); check("rd_byte2_wrap", rb, 8'h33);
        check("rd_oe_after_nack", bus.sda_oe, 0);
        check("rd_busy_after_nack", bus.busy, 0);
        check("rd_state_ignore", bus.dbg_state, 7);
        i2c_stop();
        i2c_start();
        write_byte(8'h45, ack); check("rd2_addr_ack", ack, 0);
        read_byte(1'b1, rb); check("rd2_ptr_persist", rb, 8'hC3);
        i2c_stop();
        check_wr("rd_nowrite");

        // Wrong address
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        i2c_start();
        write_byte(8'h46, ack); check("bad_addr_nack", ack, 1);
        write_byte(8'h03, ack); check("bad_data_nack", ack, 1);
        i2c_stop();
        wait_clks(2);
        check("bad_no_oe", oe_cnt - oe0, 0);
        check("bad_no_busy", busy_cnt - busy0, 0);
        check_wr("bad_nowrite");
        host_check("bad_reg3", 4'd3, 8'hA5);

        // Glitches on SCL
        i2c_start();
        write_byte(8'h44, ack); check("gl_addr_ack", ack, 0);
        write_byte(8'h07, ack); check("gl_ptr_ack", ack, 0);
        exp_q.push_back({4'd7, 8'h96});
        write_byte_glitch(8'h96, ack); check("gl_data_ack", ack, 0);
        i2c_stop();
        check_wr("gl_pulse");
        host_check("gl_reg7", 4'd7, 8'h96);

        // Host/I2C collisions
        i2c_start();
        write_byte(8'h44, ack); check("col_addr_ack", ack, 0);
        write_byte(8'h05, ack); check("col_ptr_ack", ack, 0);
        exp_q.push_back({4'd5, 8'h77});
        exp_q.push_back({4'd6, 8'h88});
        write_byte_col(8'h77, 4'd5, 8'hEE, ack, rb);
        check("col_same_ack", ack, 0);
        check("col_same_rdata", rb, 8'h77);
        write_byte_col(8'h88, 4'd9, 8'h99, ack, rb);
        check("col_diff_ack", ack, 0);
        check("col_diff_rdata", rb, 8'h99);
        i2c_stop();
        check_wr("col_pulse");
        host_check("col_reg5", 4'd5, 8'h77);
        host_check("col_reg6", 4'd6, 8'h88);
        host_check("col_reg9", 4'd9, 8'h99);

        // Reset while the target drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(8'h44 >> i);
        sda_m = 1'b1;
        check("mid_oe_before", bus.sda_oe, 1);
        check("mid_busy_before", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_oe_async", bus.sda_oe, 0);
        check("mid_busy_async", bus.busy, 0);
        scl_m = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(10);
        check("mid_state", bus.dbg_state, 0);
        host_check("mid_reg3", 4'd3, 8'h00);
        host_check("mid_reg7", 4'd7, 8'h00);
        host_write(4'd0, 8'h5C);
        i2c_start();
        write_byte(8'h45, ack); check("mid_rd_ack", ack, 0);
        read_byte(1'b1, rb); check("mid_ptr_zero", rb, 8'h5C);
        i2c_stop();
        check_wr("mid_nowrite");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Synthesizable, parametrised I2C target with an internal register file, replacing the behavioural target model for RTL-level and FPGA use. It samples SCL/SDA with a system clock, detects START/STOP, matches a 7-bit address, and supports pointer-addressed multi-byte writes and auto-incrementing reads with repeated START. A host-side port preloads registers and reports each I2C register write.

## Interface
Parameters:
- TARGET_ADDR, 7'h22, 7-bit I2C address this target acknowledges
- REG_DEPTH, 16, number of 8-bit registers; power of two, 2..256
- PTR_W, $clog2(REG_DEPTH), register pointer width (derived, not overridden)
- FILTER_LEN, 3, consecutive equal samples required before a filtered SCL/SDA change is accepted (1..7)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- scl_i  in  1  SCL pin level
- sda_i  in  1  SDA pin level
- sda_oe  out  1  1 = pull SDA low (open-drain); pad drives 0 when set, releases otherwise
- busy  out  1  high from address match until STOP/START/NACK ends the transfer
- host_we  in  1  host register write strobe
- host_addr  in  PTR_W  host register index (write and read)
- host_wdata  in  8  host write data
- host_rdata  out  8  regs[host_addr], registered (1-cycle latency)
- wr_valid  out  1  one-cycle pulse: I2C wrote a register
- wr_addr  out  PTR_W  index written (valid with wr_valid)
- wr_data  out  8  byte written (valid with wr_valid)

## Operation
- Input path: 2-flop synchronizer per pin, then glitch filter: filtered value changes only after FILTER_LEN consecutive equal synchronized samples. Edge detect on filtered scl_f/sda_f.
- START: sda_f falls while scl_f high. STOP: sda_f rises while scl_f high. Both override every state.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- IDLE --START--> ADDR. Any state --START--> ADDR (repeated START; sda_oe released). Any state --STOP--> IDLE.
- ADDR: shift 8 bits MSB-first on scl_f rising. Addr == TARGET_ADDR -> ADDR_ACK; otherwise (incl. general call 0x00) -> IGNORE, no ACK.
- ADDR_ACK: assert sda_oe for ACK bit. R/W=0 -> WR_BYTE; R/W=1 -> RD_BYTE, loading regs[ptr] into shift register, ptr++.
- WR_BYTE: first byte after address+W is the pointer (ptr = byte[PTR_W-1:0], upper bits ignored, no register write). Subsequent bytes: regs[ptr] <= byte, wr_valid pulse with wr_addr=ptr, wr_data=byte, then ptr++. Each byte -> WR_ACK (always ACK) -> WR_BYTE.
- RD_BYTE: drive bit MSB-first; sda_oe = ~bit. After 8 bits -> RD_ACK, sda_oe released.
- RD_ACK: sample master bit on scl_f rising: 0 (ACK) -> RD_BYTE loading regs[ptr], ptr++; 1 (NACK) -> IGNORE.
- IGNORE: sda_oe 0, wait for START/STOP.
- Pointer wraps modulo REG_DEPTH (REG_DEPTH-1 -> 0). Pointer persists across transfers; reset to 0 only by rst_n.
- Host/I2C write collision on same index in same cycle: I2C write wins; different indexes both complete.
- No clock stretching; SCL never driven.

## Timing
- Reset (async assert): sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, host_rdata=0, all regs=0, ptr=0, state IDLE, filters=1 (idle bus). sda_oe drops immediately on rst_n assertion.
- Pin-to-filtered latency: 2 + FILTER_LEN clk. Requirement: SCL high and low phases each ≥ FILTER_LEN+6 clk; SDA setup after SCL falling ≥ FILTER_LEN+4 clk.
- Data sampled the clk cycle scl_f rise is detected; sda_oe updated the clk cycle after scl_f fall is detected, held until next scl_f fall.
- ACK: sda_oe asserted on scl_f fall after 8th bit, released on following scl_f fall.
- regs write and wr_valid: same cycle, on the scl_f rising edge sampling bit 0 of the data byte.
- busy rises on the 8th address bit sample when matched; falls the cycle STOP/START is detected or on NACK.
- START and scl_f edge in same cycle: START takes priority.

## Test plan
- Reset mid-ACK: assert rst_n=0 while sda_oe=1 -> sda_oe=0 same cycle, regs=0, busy=0.
- Write: START, 0x44 (0x22+W), 0x03, 0xA5, 0x5A, STOP -> 3 ACKs on data/ptr plus address ACK; regs[3]=0xA5, regs[4]=0x5A; two wr_valid pulses (3,0xA5),(4,0x5A).
- Read with repeated START: host preloads regs[14]=0x11, regs[15]=0x22, regs[0]=0x33; START,0x44,0x0E,Sr,0x45, master ACK, ACK, NACK, STOP -> bytes 0x11,0x22,0x33 (wrap), ptr=1, sda_oe released after NACK.
- Wrong address: START, 0x46 -> no ACK (SDA high in 9th bit), busy stays 0, no sda_oe for whole transfer.
- Glitch: 1-clk SCL pulses (< FILTER_LEN) during data byte -> ignored; byte received correctly.
- Collision: host_we to index 5 in the same cycle as I2C write of 0x77 to 5 -> regs[5]=0x77; host_rdata(5)=0x77 next cycle.
